// File: rtl/ternary_neuron_acc.sv
// Ternary neuron accumulator: sums (pc_pos - pc_neg) over a frame and thresholds to {-1,0,+1}.
// Optional saturating accumulator enabled by defining TERNARY_NEURON_ACC_SAT_EN.
module ternary_neuron_acc #(
  parameter int PC_W      = 5,
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 16,
  parameter int TH_HI     = 2,
  parameter int TH_LO     = -2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [PC_W-1:0]  pc_pos,
  input  logic [PC_W-1:0]  pc_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overrun
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic signed [ACC_W-1:0] TH_HI_C = ACC_W'(TH_HI);
  localparam logic signed [ACC_W-1:0] TH_LO_C = ACC_W'(TH_LO);

  typedef enum logic {ACC, RESULT} state_t;

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]         beat_cnt, beat_cnt_next;
  logic signed [PC_W:0]     delta;
  logic signed [ACC_W-1:0]  delta_ext;
  logic [1:0]               trit_next;
  logic                     accept, done, overrun_next;

  assign accept        = in_valid & in_ready;
  assign delta         = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});
  assign delta_ext     = {{(ACC_W-PC_W-1){delta[PC_W]}}, delta};
  assign beat_cnt_next = beat_cnt + 1'b1;
  assign done          = accept & (in_last | (beat_cnt_next == CNT_W'(MAX_BEATS)));

`ifdef TERNARY_NEURON_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           sat_hit, sat_flag;

  // One guard bit: disagreeing top two bits means the true sum left the ACC_W range.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {delta_ext[ACC_W-1], delta_ext};
    sat_hit  = 1'b0;
    acc_next = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sat_hit  = 1'b1;
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_flag <= 1'b0;
    else if (accept)
      sat_flag <= sat_flag | sat_hit;
    else if (out_valid & out_ready)
      sat_flag <= 1'b0;
  end

  assign overrun_next = ~in_last | sat_flag | sat_hit;
`else
  assign acc_next     = acc + delta_ext;
  assign overrun_next = ~in_last;
`endif

  assign trit_next = (acc_next >= TH_HI_C) ? 2'b01 :
                     (acc_next <= TH_LO_C) ? 2'b11 : 2'b00;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (done) state_next = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      acc         <= '0;
      beat_cnt    <= '0;
      out_trit    <= 2'b00;
      out_sum     <= '0;
      out_overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc      <= acc_next;
        beat_cnt <= beat_cnt_next;
        if (done) begin
          out_sum     <= acc_next;
          out_trit    <= trit_next;
          out_overrun <= overrun_next;
        end
      end else if (out_valid & out_ready) begin
        acc      <= '0;
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Directed bench for ternary_neuron_acc: default instance plus an ACC_W=8 instance sharing inputs.
module tb_ternary_neuron_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [4:0] pc_pos = '0;
  logic [4:0] pc_neg = '0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_overrun;
  logic [1:0] out_trit;
  logic [9:0] out_sum;
  logic       in_ready8, out_valid8, out_overrun8;
  logic [1:0] out_trit8;
  logic [7:0] out_sum8;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  ternary_neuron_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .pc_pos(pc_pos), .pc_neg(pc_neg), .out_valid(out_valid),
    .out_ready(out_ready), .out_trit(out_trit), .out_sum(out_sum), .out_overrun(out_overrun)
  );

  ternary_neuron_acc #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_last(in_last), .pc_pos(pc_pos), .pc_neg(pc_neg), .out_valid(out_valid8),
    .out_ready(out_ready), .out_trit(out_trit8), .out_sum(out_sum8), .out_overrun(out_overrun8)
  );

  typedef struct {
    int              n;
    logic [3:0][4:0] pos;
    logic [3:0][4:0] neg;
    int              sum;
    logic [1:0]      trit;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  // Called away from the edge; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [4:0] p, input logic [4:0] n, input logic l);
    int waitc = 0;
    in_valid = 1'b1; pc_pos = p; pc_neg = n; in_last = l;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_in_ready_after"}, int'(in_ready), 1);
    check({name, "_out_valid_after"}, int'(out_valid), 0);
  endtask

  task automatic check_result(input string name, input int sum, input logic [1:0] trit,
                              input logic ovr);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_sum"}, int'($signed(out_sum)), sum);
    check({name, "_trit"}, int'(out_trit), int'(trit));
    check({name, "_overrun"}, int'(out_overrun), int'(ovr));
  endtask

  initial begin
    vecs[0] = '{2, {5'd0, 5'd0, 5'd1, 5'd1}, {5'd0, 5'd0, 5'd0, 5'd0}, 2, 2'b01};
    vecs[1] = '{1, {5'd0, 5'd0, 5'd0, 5'd3}, {5'd0, 5'd0, 5'd0, 5'd2}, 1, 2'b00};
    vecs[2] = '{2, {5'd0, 5'd0, 5'd0, 5'd0}, {5'd0, 5'd0, 5'd1, 5'd1}, -2, 2'b11};
    vecs[3] = '{1, {5'd0, 5'd0, 5'd0, 5'd2}, {5'd0, 5'd0, 5'd0, 5'd3}, -1, 2'b00};
    vecs[4] = '{1, {5'd0, 5'd0, 5'd0, 5'd7}, {5'd0, 5'd0, 5'd0, 5'd7}, 0, 2'b00};
    vecs[5] = '{2, {5'd0, 5'd0, 5'd0, 5'd31}, {5'd0, 5'd0, 5'd28, 5'd0}, 3, 2'b01};
    vecs[6] = '{4, {5'd28, 5'd0, 5'd1, 5'd0}, {5'd0, 5'd31, 5'd0, 5'd1}, -3, 2'b11};

    // Reset state
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_trit", int'(out_trit), 0);
    check("rst_out_overrun", int'(out_overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);

    // Reset mid-frame discards the partial sum
    for (int i = 0; i < 3; i++) send_beat(5'd5, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_beat(5'd1, 5'd0, 1'b1);
    check_result("midrst", 1, 2'b00, 1'b0);
    take_result("midrst");

    // Table: threshold edges and mixed frames
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        send_beat(vecs[v].pos[b], vecs[v].neg[b], b == vecs[v].n - 1);
      check_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].trit, 1'b0);
      take_result($sformatf("vec%0d", v));
    end

    // Backpressure: result held stable while out_ready low
    send_beat(5'd4, 5'd1, 1'b0);
    send_beat(5'd0, 5'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), int'(out_valid), 1);
      check($sformatf("bp%0d_sum", c), int'(out_sum), 0);
      check($sformatf("bp%0d_trit", c), int'(out_trit), 0);
      check($sformatf("bp%0d_in_ready", c), int'(in_ready), 0);
    end
    take_result("bp");

    // MAX_BEATS forced completion, then the held 17th beat starts a fresh frame
    for (int i = 0; i < 16; i++) send_beat(5'd1, 5'd0, 1'b0);
    check_result("max", 16, 2'b01, 1'b1);
    in_valid = 1'b1; pc_pos = 5'd2; pc_neg = 5'd0; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("max_hold%0d_in_ready", c), int'(in_ready), 0);
      check($sformatf("max_hold%0d_sum", c), int'(out_sum), 16);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("max_next_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check_result("after_max", 2, 2'b01, 1'b0);
    take_result("after_max");

    // Extremes: 5 x 31/0
    for (int i = 0; i < 5; i++) send_beat(5'd31, 5'd0, i == 4);
    check_result("ext10", 155, 2'b01, 1'b0);
    check("ext8_valid", int'(out_valid8), 1);
`ifdef TERNARY_NEURON_ACC_SAT_EN
    check("ext8_sum", int'($signed(out_sum8)), 127);
    check("ext8_trit", int'(out_trit8), 1);
    check("ext8_overrun", int'(out_overrun8), 1);
`else
    check("ext8_sum", int'($signed(out_sum8)), -101);
    check("ext8_trit", int'(out_trit8), 3);
    check("ext8_overrun", int'(out_overrun8), 0);
`endif
    take_result("ext");

    // Single beat after input stalls with junk on the data lines
    pc_pos = 5'd31; pc_neg = 5'd0; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_last = 1'b0;
    check("stall_no_result", int'(out_valid), 0);
    send_beat(5'd0, 5'd31, 1'b1);
    check_result("single", -31, 2'b11, 1'b0);
    take_result("single");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
